// File: rtl/scan_serializer_if.sv
// Signal bundle between scan_serializer, the 8255 byte selector feeding it
// and the serial sink; master is the serializer side.
interface scan_serializer_if;
  logic       start;
  logic [7:0] din;
  logic [1:0] mode_in;
  logic       sel;
  logic       sdo;
  logic       sclk;
  logic       fsync;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    input  start, din, mode_in,
    output sel, sdo, sclk, fsync, busy, done, err
  );

  modport slave (
    output start, din, mode_in,
    input  sel, sdo, sclk, fsync, busy, done, err
  );
endinterface

// File: rtl/scan_serializer.sv
// Serializes the four bytes of the 8255 selector MSB first with a bit clock,
// stepping the selector with an active-low sel pulse after every byte.
module scan_serializer #(
  parameter int DIV    = 4,
  parameter int SETTLE = 2,
  parameter int BYTES  = 4
) (
  input logic               clk,
  input logic               reset,
  scan_serializer_if.master bus
);
  localparam int CMAX = (DIV > SETTLE) ? DIV : SETTLE;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] DIV_LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST   = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [1:0]    IDX_LAST    = 2'(BYTES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_ADVANCE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [1:0]    idx;
  logic [7:0]    shreg;
  logic          sel_q;
  logic          sdo_q;
  logic          sclk_q;
  logic          fsync_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  // Outputs are updated on the transition into the cycle they describe,
  // so every serial pin is a plain flop with no path from the inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      idx     <= '0;
      shreg   <= '0;
      sel_q   <= 1'b1;
      sdo_q   <= 1'b0;
      sclk_q  <= 1'b0;
      fsync_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_SETTLE;
            cnt    <= '0;
            idx    <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
          end
        end

        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= S_LOAD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_LOAD: begin
          shreg   <= bus.din;
          sdo_q   <= bus.din[7];
          sclk_q  <= 1'b0;
          fsync_q <= (idx == 2'd0);
          cnt     <= '0;
          bit_cnt <= '0;
          if (bus.mode_in != idx) begin
            err_q <= 1'b1;
          end
          state <= S_SHIFT;
        end

        // sdo presents shreg[7]; the bit is replaced at the period boundary.
        S_SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            sclk_q  <= 1'b0;
            fsync_q <= 1'b0;
            shreg   <= {shreg[6:0], 1'b0};
            if (bit_cnt == 3'd7) begin
              sdo_q <= 1'b0;
              sel_q <= 1'b0;
              state <= S_ADVANCE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              sdo_q   <= shreg[6];
            end
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == HALF_LAST) begin
              sclk_q <= 1'b1;
            end
          end
        end

        S_ADVANCE: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            sel_q <= 1'b1;
            if (idx == IDX_LAST) begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              idx   <= idx + 2'd1;
              state <= S_SETTLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sel   = sel_q;
  assign bus.sdo   = sdo_q;
  assign bus.sclk  = sclk_q;
  assign bus.fsync = fsync_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_scan_serializer.sv
// Bench for scan_serializer: behavioural 8255 selector models drive two
// instances (DIV=4/SETTLE=2 and DIV=2/SETTLE=1); a frame monitor is compared to a stream model.
module tb_scan_serializer;
  localparam int BYTES    = 4;
  localparam int DIV_A    = 4;
  localparam int SETTLE_A = 2;
  localparam int DIV_B    = 2;
  localparam int SETTLE_B = 1;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [31:0] stream;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       use_b;
  logic       force_en;
  logic [1:0] force_val;
  logic [7:0] in_bytes [4];
  logic [1:0] mode_a;
  logic [1:0] mode_b;

  int n_checks = 0;
  int n_fail   = 0;

  int   got_bits[$];
  int   sel_runs[$];
  int   done_cycles[$];
  int   fsync_pulses;
  int   fsync_cycles;
  int   busy_cycles;
  int   first_rise;
  logic err_first;
  logic err_end;
  logic busy_after;
  logic err_at_load;
  logic err_after_load;

  always #5 clk = ~clk;

  scan_serializer_if bus_a ();
  scan_serializer_if bus_b ();

  scan_serializer #(.DIV(DIV_A), .SETTLE(SETTLE_A), .BYTES(BYTES)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  scan_serializer #(.DIV(DIV_B), .SETTLE(SETTLE_B), .BYTES(BYTES)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  // Selector model: mode resets with the serializer and steps on each sel fall.
  always @(negedge bus_a.sel or negedge reset) begin
    if (!reset) mode_a <= 2'd0;
    else        mode_a <= mode_a + 2'd1;
  end

  always @(negedge bus_b.sel or negedge reset) begin
    if (!reset) mode_b <= 2'd0;
    else        mode_b <= mode_b + 2'd1;
  end

  assign bus_a.din     = in_bytes[mode_a];
  assign bus_a.mode_in = force_en ? force_val : mode_a;
  assign bus_a.start   = start & ~use_b;
  assign bus_b.din     = in_bytes[mode_b];
  assign bus_b.mode_in = mode_b;
  assign bus_b.start   = start & use_b;

  logic m_sel, m_sdo, m_sclk, m_fsync, m_busy, m_done, m_err;
  assign m_sel   = use_b ? bus_b.sel   : bus_a.sel;
  assign m_sdo   = use_b ? bus_b.sdo   : bus_a.sdo;
  assign m_sclk  = use_b ? bus_b.sclk  : bus_a.sclk;
  assign m_fsync = use_b ? bus_b.fsync : bus_a.fsync;
  assign m_busy  = use_b ? bus_b.busy  : bus_a.busy;
  assign m_done  = use_b ? bus_b.done  : bus_a.done;
  assign m_err   = use_b ? bus_b.err   : bus_a.err;

  function automatic int modelFrameLen(input int div, input int settle);
    return 1 + BYTES * (settle + 1 + 8 * div + div);
  endfunction

  function automatic logic [63:0] modelStream(input int nframes);
    logic [63:0] s = '0;
    for (int f = 0; f < nframes; f++)
      for (int b = 0; b < BYTES; b++)
        s = (s << 8) | 64'(in_bytes[b]);
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
    in_bytes[0] = b0;
    in_bytes[1] = b1;
    in_bytes[2] = b2;
    in_bytes[3] = b3;
  endtask

  // hook 1: extra start at hook_cyc, 2: force mode_in=2 at hook_cyc,
  // 3: reset at hook_cyc and abort, 4: hold start for back-to-back frames.
  task automatic runFrame(input int div, input int settle, input int nframes,
                          input int hook, input int hook_cyc);
    int   flen;
    int   limit;
    int   run;
    logic prev_sclk;
    logic prev_fsync;
    flen  = modelFrameLen(div, settle);
    limit = nframes * (flen + 1) + 3;
    got_bits.delete();
    sel_runs.delete();
    done_cycles.delete();
    fsync_pulses = 0;
    fsync_cycles = 0;
    busy_cycles  = 0;
    first_rise   = -1;
    run          = 0;
    prev_sclk    = 1'b0;
    prev_fsync   = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (hook != 4) start = 1'b0;
    for (int rel = 1; rel <= limit; rel++) begin
      @(negedge clk);
      if (m_sclk && !prev_sclk) begin
        got_bits.push_back(int'(m_sdo));
        if (first_rise < 0) first_rise = rel;
      end
      prev_sclk = m_sclk;
      if (!m_sel) run++;
      else if (run > 0) begin
        sel_runs.push_back(run);
        run = 0;
      end
      if (m_fsync) fsync_cycles++;
      if (m_fsync && !prev_fsync) fsync_pulses++;
      prev_fsync = m_fsync;
      if (m_busy) busy_cycles++;
      if (m_done) done_cycles.push_back(rel);
      if (rel == 1) err_first = m_err;
      if (rel == flen) err_end = m_err;
      if (rel == flen + 1) busy_after = m_busy;
      if (hook == 1 && rel == hook_cyc) start = 1'b1;
      if (hook == 1 && rel == hook_cyc + 1) start = 1'b0;
      if (hook == 2 && rel == hook_cyc) begin
        err_at_load = m_err;
        force_en    = 1'b1;
        force_val   = 2'd2;
      end
      if (hook == 2 && rel == hook_cyc + 1) begin
        err_after_load = m_err;
        force_en       = 1'b0;
      end
      if (hook == 3 && rel == hook_cyc) begin
        checkOutput("abort_sel_low_before_reset", m_sel, 0);
        reset = 1'b0;
        #1;
        checkOutput("abort_sel_sdo_busy_done", {m_sel, m_sdo, m_busy, m_done}, 4'b1000);
        repeat (2) @(negedge clk);
        checkOutput("abort_selector_mode", mode_a, 0);
        reset = 1'b1;
        break;
      end
      if (hook == 4 && rel == nframes * (flen + 1)) start = 1'b0;
    end
  endtask

  task automatic checkFrame(input string name, input logic [63:0] exp_stream,
                            input int nframes, input int div, input int settle);
    int          flen;
    int          bad;
    logic [63:0] got;
    flen = modelFrameLen(div, settle);
    got  = '0;
    bad  = 0;
    checkOutput({name, "_bit_count"}, got_bits.size(), 32 * nframes);
    for (int i = 0; i < got_bits.size() && i < 64; i++) got = {got[62:0], got_bits[i][0]};
    checkOutput({name, "_stream"}, got, exp_stream);
    checkOutput({name, "_sel_pulses"}, sel_runs.size(), BYTES * nframes);
    foreach (sel_runs[i]) if (sel_runs[i] != div) bad++;
    checkOutput({name, "_sel_width_errors"}, bad, 0);
    checkOutput({name, "_done_count"}, done_cycles.size(), nframes);
    if (done_cycles.size() > 0) checkOutput({name, "_done_cycle"}, done_cycles[0], flen);
    if (done_cycles.size() > 1) checkOutput({name, "_done_cycle2"}, done_cycles[1], 2 * flen + 1);
    checkOutput({name, "_first_sclk_rise"}, first_rise, settle + 2 + div / 2);
    checkOutput({name, "_fsync_pulses"}, fsync_pulses, nframes);
    checkOutput({name, "_fsync_cycles"}, fsync_cycles, nframes * div);
    checkOutput({name, "_busy_cycles"}, busy_cycles, nframes * flen);
    checkOutput({name, "_busy_after_done"}, busy_after, 0);
    checkOutput({name, "_selector_wrapped"}, use_b ? mode_b : mode_a, 0);
  endtask

  initial begin
    vec_t vecs [4];
    vecs[0] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 32'hA53CFF00};
    vecs[1] = '{8'h01, 8'h80, 8'h7E, 8'hC3, 32'h01807EC3};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
    vecs[3] = '{8'h00, 8'h5A, 8'h00, 8'h96, 32'h005A0096};

    reset     = 1'b1;
    start     = 1'b0;
    use_b     = 1'b0;
    force_en  = 1'b0;
    force_val = 2'd0;
    applyStimulus(8'hA5, 8'h3C, 8'hFF, 8'h00);
    #2 reset = 1'b0;
    #1;
    checkOutput("reset_outputs_a", {bus_a.sel, bus_a.sdo, bus_a.sclk, bus_a.fsync,
                                    bus_a.busy, bus_a.done, bus_a.err}, 7'b1000000);
    checkOutput("reset_outputs_b", {bus_b.sel, bus_b.sdo, bus_b.sclk, bus_b.fsync,
                                    bus_b.busy, bus_b.done, bus_b.err}, 7'b1000000);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
      runFrame(DIV_A, SETTLE_A, 1, 0, 0);
      checkFrame("table", {32'h0, vecs[i].stream}, 1, DIV_A, SETTLE_A);
      checkOutput("table_err", err_end, 0);
    end

    $display("[TB] start while busy");
    applyStimulus(8'hA5, 8'h3C, 8'hFF, 8'h00);
    runFrame(DIV_A, SETTLE_A, 1, 1, 50);
    checkFrame("busy_start", 64'hA53CFF00, 1, DIV_A, SETTLE_A);

    $display("[TB] index mismatch on byte 1");
    runFrame(DIV_A, SETTLE_A, 1, 2, 42);
    checkOutput("mismatch_err_in_load", err_at_load, 0);
    checkOutput("mismatch_err_after_load", err_after_load, 1);
    checkOutput("mismatch_err_at_done", err_end, 1);
    checkFrame("mismatch", 64'hA53CFF00, 1, DIV_A, SETTLE_A);
    checkOutput("mismatch_err_sticky_idle", bus_a.err, 1);
    runFrame(DIV_A, SETTLE_A, 1, 0, 0);
    checkOutput("err_cleared_by_start", err_first, 0);
    checkOutput("err_clear_frame_end", err_end, 0);

    $display("[TB] reset during byte 2 advance");
    runFrame(DIV_A, SETTLE_A, 1, 3, 115);
    checkOutput("abort_no_done", done_cycles.size(), 0);
    runFrame(DIV_A, SETTLE_A, 1, 0, 0);
    checkFrame("after_abort", 64'hA53CFF00, 1, DIV_A, SETTLE_A);
    checkOutput("after_abort_err", err_end, 0);

    $display("[TB] back-to-back frames");
    runFrame(DIV_A, SETTLE_A, 2, 4, 0);
    checkFrame("back_to_back", 64'hA53CFF00_A53CFF00, 2, DIV_A, SETTLE_A);

    repeat (4) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      runFrame(DIV_A, SETTLE_A, 1, 0, 0);
      checkFrame("random_a", modelStream(1), 1, DIV_A, SETTLE_A);
      checkOutput("random_a_err", err_end, 0);
    end

    $display("[TB] DIV=2 SETTLE=1 instance");
    use_b = 1'b1;
    applyStimulus(vecs[0].b0, vecs[0].b1, vecs[0].b2, vecs[0].b3);
    runFrame(DIV_B, SETTLE_B, 1, 0, 0);
    checkFrame("div2_table", {32'h0, vecs[0].stream}, 1, DIV_B, SETTLE_B);
    repeat (2) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      runFrame(DIV_B, SETTLE_B, 1, 0, 0);
      checkFrame("div2_random", modelStream(1), 1, DIV_B, SETTLE_B);
      checkOutput("div2_random_err", err_end, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
